shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_pkg.sv | 37 +++
 rtl/shift_step.sv | 24 ++
 rtl/shift_seq.sv | 102 ++++++++++
 tb/tb_shift_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants, sel codes and FSM state type for the sequential shifter.
// Optional rotate-right support is enabled by defining SHIFT_SEQ_ROR_EN.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_NOP  = 3'b000;
  localparam logic [SEL_W-1:0] SEL_LOAD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_SLL  = 3'b010;
  localparam logic [SEL_W-1:0] SEL_SRL  = 3'b011;
  localparam logic [SEL_W-1:0] SEL_SRA  = 3'b100;
  localparam logic [SEL_W-1:0] SEL_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // True for codes that consume amt cycles of single-bit steps.
  function automatic logic sel_is_shift(input logic [SEL_W-1:0] sel);
    logic is_shift;
    is_shift = (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);
`ifdef SHIFT_SEQ_ROR_EN
    is_shift = is_shift || (sel == SEL_ROR);
`endif
    return is_shift;
  endfunction

  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    return (sel == SEL_NOP) || (sel == SEL_LOAD) || sel_is_shift(sel);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step selected by the operation code.
// Rotate-right is only built when SHIFT_SEQ_ROR_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] step_value
);

  always_comb begin
    step_value = value;
    case (sel)
      SEL_SLL: step_value = {value[DATA_W-2:0], 1'b0};
      SEL_SRL: step_value = {1'b0, value[DATA_W-1:1]};
      SEL_SRA: step_value = {value[DATA_W-1], value[DATA_W-1:1]};
`ifdef SHIFT_SEQ_ROR_EN
      SEL_ROR: step_value = {value[0], value[DATA_W-1:1]};
`endif
      default: step_value = value;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one bit position per cycle, IDLE/LOAD/SHIFT/DONE FSM.
// Define SHIFT_SEQ_ROR_EN to make sel 101 a rotate-right instead of illegal.
module shift_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] src,
  input  logic [AMT_W-1:0]  amt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  state_t            state_q,  state_d;
  logic [SEL_W-1:0]  sel_q,    sel_d;
  logic [DATA_W-1:0] src_q,    src_d;
  logic [AMT_W-1:0]  amt_q,    amt_d;
  logic [DATA_W-1:0] shreg_q,  shreg_d;
  logic [AMT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] step_value;

  shift_step u_step (
    .value      (shreg_q),
    .sel        (sel_q),
    .step_value (step_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      src_q    <= '0;
      amt_q    <= '0;
      shreg_q  <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      src_q    <= src_d;
      amt_q    <= amt_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // result is captured on entry to DONE so it is already valid while done is high.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    src_d    = src_q;
    amt_d    = amt_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = sel;
          src_d   = src;
          amt_d   = amt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shreg_d = src_q;
        count_d = sel_is_shift(sel_q) ? amt_q : '0;
        if (count_d != '0) begin
          state_d = ST_SHIFT;
        end else begin
          state_d  = ST_DONE;
          result_d = src_q;
        end
      end
      ST_SHIFT: begin
        shreg_d = step_value;
        count_d = count_q - 1'b1;
        if (count_q <= 1) begin
          count_d  = '0;
          state_d  = ST_DONE;
          result_d = step_value;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = (state_q == ST_DONE) && !sel_is_legal(sel_q);
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: scoreboard of expected completions vs. a monitor.
// Honors SHIFT_SEQ_ROR_EN to pick the expected sel 101 behaviour.
module tb_shift_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  sel;
  logic [31:0] src;
  logic [4:0]  amt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  shift_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sel    (sel),
    .src    (src),
    .amt    (amt),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operation arithmetic, independent of the per-cycle stepping.
  function automatic void model(input logic [2:0] s, input logic [31:0] x, input logic [4:0] a,
                                output logic [31:0] r, output logic e, output int lat);
    r = x; e = 1'b0; lat = 2;
    case (s)
      3'd0, 3'd1: ;
      3'd2: begin r = x << a; lat = 2 + int'(a); end
      3'd3: begin r = x >> a; lat = 2 + int'(a); end
      3'd4: begin r = $signed(x) >>> a; lat = 2 + int'(a); end
`ifdef SHIFT_SEQ_ROR_EN
      3'd5: begin r = (x >> a) | (x << (6'd32 - {1'b0, a})); lat = 2 + int'(a); end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (err === 1'b1 && done !== 1'b1) chk("err_without_done", {31'd0, err}, 32'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("done_cycle", cyc, e.cyc);
          $display("op done cycle=%0d result=%h err=%0b", cyc, result, err);
        end
      end
    end
  end

  // Issues one request once the DUT is idle; returns at the negedge of cycle T+1.
  task automatic issue(input logic [2:0] s, input logic [31:0] x, input logic [4:0] a);
    int n;
    exp_t e;
    int lat;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", {31'd0, busy}, 32'd0);
    start = 1'b1; sel = s; src = x; amt = a;
    model(s, x, a, e.res, e.err, lat);
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    sel = 3'($urandom); src = $urandom; amt = 5'($urandom);
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", sb.size(), 32'd0);
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sel = '0; src = '0; amt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd2, 32'h0000_0001, 5'd4);
    drain(1);
    issue(3'd4, 32'h8000_0000, 5'd31);
    drain(1);
    issue(3'd3, 32'h8000_0000, 5'd31);
    drain(1);

    // amt=0: busy only during T+1..T+2
    chk("busy_before", {31'd0, busy}, 32'd0);
    issue(3'd3, 32'hDEAD_BEEF, 5'd0);
    chk("busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_t2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_t3", {31'd0, busy}, 32'd0);
    drain(1);

    // Second start while busy must be ignored.
    issue(3'd2, 32'h1234_5678, 5'd8);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; sel = 3'd3; src = $urandom; amt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    drain(15);

    // Reset mid-operation aborts with no done.
    issue(3'd4, $urandom, 5'd20);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (30) @(negedge clk);

    // start coincident with reset is ignored.
    reset = 1'b1; start = 1'b1; sel = 3'd2; src = 32'hFFFF_FFFF; amt = 5'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    issue(3'd5, 32'h0000_0001, 5'd1);
    drain(1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] s;
      logic [4:0] a;
      s = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      issue(s, $urandom, a);
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) drain(0);
    end
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
